// File: rtl/dti_queue_pkg.sv
// dti_queue_pkg: shared constants and helpers for eot-framed dti stream stages.
// Eot bits sit directly above the payload: level L lives at bit (W_DATA + L),
// so the outermost level is always the MSB of the word.
package dti_queue_pkg;

    // Bit offsets of each eot level above the payload field
    localparam int EOT_LVL0 = 0;
    localparam int EOT_LVL1 = 1;

    // Widest word the packing helper can build
    localparam int EOT_PACK_W = 64;

    // Builds {lvl1, lvl0, data[w_data-1:0]} right-aligned in a 64-bit word.
    // Callers cast the result down to their own word width.
    function automatic logic [EOT_PACK_W-1:0] eot_pack(
        input logic                  lvl1,
        input logic                  lvl0,
        input logic [EOT_PACK_W-1:0] data,
        input int                    w_data
    );
        logic [EOT_PACK_W-1:0] r_word;
        r_word = '0;
        for (int i = 0; i < EOT_PACK_W; i++) begin
            if (i < w_data) begin
                r_word[i] = data[i];
            end else if (i == w_data + EOT_LVL0) begin
                r_word[i] = lvl0;
            end else if (i == w_data + EOT_LVL1) begin
                r_word[i] = lvl1;
            end
        end
        return r_word;
    endfunction

endpackage

// File: rtl/dti.sv
// dti: valid/ready stream interface carrying one data word.
// A word moves on every rising clk edge where valid and ready are both high.
// valid must not depend on ready; once valid is raised with a word, that word
// and valid are held until the transfer happens.
interface dti #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/dti_skid.sv
// dti_skid: 2-entry width-generic skid buffer for dti stages.
// o_ready comes only from the occupancy register, so the upstream ready has no
// combinational path from i_ready. With i_ready held high the buffer sits at
// one entry and passes one word per cycle with one cycle of latency.
module dti_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    // Pointer and occupancy bookkeeping; reset drops any buffered words
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/chop.sv
// chop: splits each eot-terminated input transaction into chunks of cfg items.
// dout = {eot[1], eot[0], data}: eot[0] closes each chunk (or the transaction),
// eot[1] copies the input eot. cfg is held for a whole transaction and is
// consumed on the item that carries the input eot.
// Build option CHOP_OUT_REG_EN: drive dout from a 2-entry skid buffer
// (1-cycle latency, din.ready independent of dout.ready). Without it the
// datapath is purely combinational with zero latency.
module chop
    import dti_queue_pkg::*;
(
    input logic  clk,
    input logic  rst,
    dti.consumer cfg,
    dti.consumer din,
    dti.producer dout
);

    localparam int W_DATA = $bits(din.data) - 1;
    localparam int W_CFG  = $bits(cfg.data);

    logic              w_in_eot;
    logic [W_DATA-1:0] w_in_data;
    logic [W_CFG-1:0]  r_cnt;
    logic [W_CFG-1:0]  w_cnt_next;
    logic              w_eot0;
    logic              w_in_valid;
    logic              w_din_ready;
    logic              w_accept;
    logic [W_DATA+1:0] w_out_word;

    assign w_in_eot  = din.data[W_DATA];
    assign w_in_data = din.data[W_DATA-1:0];

    // Wraps modulo 2^W_CFG, so cfg = 0 closes a chunk every 2^W_CFG items
    assign w_cnt_next = r_cnt + W_CFG'(1);
    assign w_eot0     = (w_cnt_next == cfg.data) | w_in_eot;

    assign w_out_word = (W_DATA + 2)'(eot_pack(w_in_eot, w_eot0,
                                               EOT_PACK_W'(w_in_data), W_DATA));

    // Reset is folded into the handshakes so nothing is accepted, emitted or
    // consumed from cfg while rst is high.
    assign w_in_valid = din.valid & cfg.valid & ~rst;
    assign w_accept   = din.valid & w_din_ready;
    assign din.ready  = w_din_ready;
    assign cfg.ready  = w_accept & w_in_eot;

    // Item counter: advances on every accepted item, restarts after a chunk end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_eot0) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

`ifdef CHOP_OUT_REG_EN
    logic w_skid_in_ready;

    dti_skid #(
        .W (W_DATA + 2)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_in_valid),
        .o_ready (w_skid_in_ready),
        .i_data  (w_out_word),
        .o_valid (dout.valid),
        .i_ready (dout.ready),
        .o_data  (dout.data)
    );

    // Ready depends only on the skid occupancy register, never on dout.ready
    assign w_din_ready = cfg.valid & w_skid_in_ready & ~rst;
`else
    assign w_din_ready = cfg.valid & dout.ready & ~rst;
    assign dout.valid  = w_in_valid;
    assign dout.data   = w_out_word;
`endif

endmodule

// File: tb/tb_chop.sv
// tb_chop: scoreboard bench for chop. Instance a uses a 3-bit cfg, instance b
// a 2-bit cfg for the chunk-size-wraps-at-zero case. Works in both builds
// (CHOP_OUT_REG_EN defined or not).
`timescale 1ns/1ps
module tb_chop;

    localparam int W_DATA = 8;
    localparam int W_OUT  = W_DATA + 2;
`ifdef CHOP_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;

    dti #(.W(3))        cfg_a  ();
    dti #(.W(W_DATA+1)) din_a  ();
    dti #(.W(W_OUT))    dout_a ();
    dti #(.W(2))        cfg_b  ();
    dti #(.W(W_DATA+1)) din_b  ();
    dti #(.W(W_OUT))    dout_b ();

    chop u_chop_a (.clk(clk), .rst(rst), .cfg(cfg_a), .din(din_a), .dout(dout_a));
    chop u_chop_b (.clk(clk), .rst(rst), .cfg(cfg_b), .din(din_b), .dout(dout_b));

    int               n_total;
    int               n_bad;
    logic [W_OUT-1:0] exp_q[$];
    logic [W_OUT-1:0] exp_b_q[$];
    int               acc_q[$];
    int               cyc;
    int               pos_a;
    int               pos_b;
    int               cfg_used;
    int               gap_max;
    int               rdy_mode;
    bit               lat_chk;
    int               last_acc;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    // dout_a.ready: mode 0 always ready, mode 1 repeats 1,0,0
    initial begin
        int ph;
        ph = 0;
        dout_a.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                dout_a.ready = 1'b1;
            end else begin
                dout_a.ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // cfg consumptions of instance a, counted whenever they happen (reset included)
    initial begin
        cfg_used = 0;
        forever begin
            @(negedge clk);
            if (cfg_a.valid && cfg_a.ready) cfg_used++;
        end
    end

    task automatic send_a(input logic [W_DATA-1:0] d, input logic e);
        int   g;
        bit   done;
        int   sz;
        logic eot0;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        din_a.valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        din_a.valid = 1'b1;
        din_a.data  = {e, d};
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (din_a.ready) begin
                sz = (cfg_a.data == 3'd0) ? 8 : int'(cfg_a.data);
                pos_a++;
                eot0 = (pos_a == sz) || e;
                if (eot0) pos_a = 0;
                exp_q.push_back({e, eot0, d});
                acc_q.push_back(cyc);
                last_acc = cyc;
                check("cfg_ready", {31'd0, cfg_a.ready}, {31'd0, e});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("din_a_accept", {31'd0, din_a.ready}, 32'd1);
        din_a.valid = 1'b0;
    endtask

    task automatic send_txn_a(input int first, input int n, input bit rnd);
        logic [W_DATA-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? W_DATA'($urandom_range(255, 0)) : W_DATA'(first + i);
            send_a(d, (i == n - 1));
        end
    endtask

    task automatic send_b(input logic [W_DATA-1:0] d, input logic e);
        bit   done;
        int   sz;
        logic eot0;
        din_b.valid = 1'b1;
        din_b.data  = {e, d};
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (din_b.ready) begin
                sz = (cfg_b.data == 2'd0) ? 4 : int'(cfg_b.data);
                pos_b++;
                eot0 = (pos_b == sz) || e;
                if (eot0) pos_b = 0;
                exp_b_q.push_back({e, eot0, d});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("din_b_accept", {31'd0, din_b.ready}, 32'd1);
        din_b.valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && exp_b_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_a", exp_q.size(), 0);
        check("drain_b", exp_b_q.size(), 0);
    endtask

    // ---------------- scoreboard monitors ----------------
    initial begin
        logic             stalled;
        logic [W_OUT-1:0] held;
        logic [W_OUT-1:0] e;
        int               a;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", {31'd0, dout_a.valid}, 32'd1);
                    check("stall_data", {22'd0, dout_a.data}, {22'd0, held});
                end
                if (dout_a.valid && dout_a.ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_a_extra", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("dout_a", {22'd0, dout_a.data}, {22'd0, e});
                        if (lat_chk) check("latency", cyc - a, LAT);
                    end
                end
                stalled = dout_a.valid && !dout_a.ready;
                held    = dout_a.data;
            end
        end
    end

    initial begin
        logic [W_OUT-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && dout_b.valid && dout_b.ready) begin
                if (exp_b_q.size() == 0) begin
                    check("sb_b_extra", exp_b_q.size(), 1);
                end else begin
                    e = exp_b_q.pop_front();
                    check("dout_b", {22'd0, dout_b.data}, {22'd0, e});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int first_acc;
        int used0;
        n_total  = 0;
        n_bad    = 0;
        pos_a    = 0;
        pos_b    = 0;
        gap_max  = 0;
        rdy_mode = 0;
        lat_chk  = 0;
        last_acc = 0;
        rst = 1'b1;
        cfg_a.valid = 1'b1;
        cfg_a.data  = 3'd3;
        cfg_b.valid = 1'b1;
        cfg_b.data  = 2'd0;
        dout_b.ready = 1'b1;
        din_b.valid = 1'b0;
        din_b.data  = '0;
        // A pending eot item during reset must not consume cfg
        din_a.valid = 1'b1;
        din_a.data  = {1'b1, 8'h55};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", {31'd0, cfg_a.ready}, 32'd0);
`ifdef CHOP_OUT_REG_EN
        check("rst_dout_valid", {31'd0, dout_a.valid}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        din_a.valid = 1'b0;
        @(negedge clk);
        check("idle_cfg_ready", {31'd0, cfg_a.ready}, 32'd0);
        check("idle_dout_valid", {31'd0, dout_a.valid}, 32'd0);
        check("rst_cfg_used", cfg_used, 0);
        @(posedge clk);
        #1;

        // cfg=3, items 1..7: chunks [1,2,3][4,5,6][7], cfg consumed once
        used0 = cfg_used;
        cfg_a.data = 3'd3;
        send_txn_a(1, 7, 0);
        wait_drain();
        check("t1_cfg_used", cfg_used - used0, 1);

        // cfg=4, items 1..8: boundary meets eot, then cfg=1 for 9,10
        cfg_a.data = 3'd4;
        send_txn_a(1, 8, 0);
        cfg_a.data = 3'd1;
        send_txn_a(9, 2, 0);
        wait_drain();

        // cfg=0 on a 2-bit counter: chunk size 4, eot[0] on items 4, 8, 9
        for (int i = 1; i <= 9; i++) send_b(W_DATA'(i), (i == 9));
        wait_drain();

        // Output backpressure 1,0,0 with random input gaps
        rdy_mode = 1;
        gap_max  = 3;
        cfg_a.data = 3'd3;
        send_txn_a(0, 10, 1);
        cfg_a.data = 3'd2;
        send_txn_a(0, 7, 1);
        cfg_a.data = 3'd0;
        send_txn_a(0, 11, 1);
        wait_drain();
        rdy_mode = 0;
        gap_max  = 0;
        @(posedge clk);
        #1;

        // Constant ready: latency and one accepted item per cycle
        lat_chk = 1;
        cfg_a.data = 3'd5;
        send_a(8'd1, 1'b0);
        first_acc = last_acc;
        for (int i = 2; i <= 8; i++) send_a(W_DATA'(i), (i == 8));
        check("throughput", last_acc - first_acc, 7);
        wait_drain();
        lat_chk = 0;

        // cfg.valid low stalls the block
        cfg_a.valid = 1'b0;
        cfg_a.data  = 3'd3;
        din_a.valid = 1'b1;
        din_a.data  = {1'b0, 8'd20};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cfgv_din_ready", {31'd0, din_a.ready}, 32'd0);
            check("cfgv_dout_valid", {31'd0, dout_a.valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        cfg_a.valid = 1'b1;
        send_txn_a(20, 3, 0);
        wait_drain();

        // Reset after two accepted items of a cfg=3 transaction
        cfg_a.data = 3'd3;
        send_a(8'd1, 1'b0);
        send_a(8'd2, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        used0 = cfg_used;
        rst = 1'b1;
        din_a.valid = 1'b1;
        din_a.data  = {1'b1, 8'h77};
        repeat (2) begin
            @(negedge clk);
            check("midrst_cfg_ready", {31'd0, cfg_a.ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        din_a.valid = 1'b0;
        pos_a = 0;
        check("midrst_cfg_used", cfg_used - used0, 0);
        send_txn_a(10, 3, 0);
        wait_drain();
        check("post_rst_cfg_used", cfg_used - used0, 1);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
